wb_slave_q: RTL and testbench
=============================

// Module: wb_slave_q
// PURPOSE
//  Next-gen Wishbone slave bridge: decodes NWIN address windows, queues commands in a DEPTH-entry FIFO
//  toward the array/config logic with a valid/ready handshake, posts writes (early ack), holds reads until
//  rd_ack, and optionally times out lost reads. Sits between the Caravel WB bus and the toysram command path.
// PARAMETERS
//  NWIN        2                          number of address windows (1..4)
//  WIN_BASE    {32'h30100000,32'h30000000} NWIN*32 flat vector; window i = bits [32*i+:32]
//  WIN_MASK    {32'hFFF00000,32'hFFF00000} NWIN*32 flat vector; 1 = address bit compared
//  DEPTH       4                          command FIFO entries (power of 2, >=2)
//  TIMEOUT     255                        read timeout in clk cycles (used only with WB_SLAVE_Q_TIMEOUT_EN)
//  TIMEOUT_DAT 32'hDEADDEAD               wbs_dat_o returned on read timeout
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active high
//  wbs_stb_i  in   1   WB strobe
//  wbs_cyc_i  in   1   WB cycle
//  wbs_we_i   in   1   WB write enable
//  wbs_sel_i  in   4   WB byte selects
//  wbs_dat_i  in   32  WB write data
//  wbs_adr_i  in   32  WB address
//  wbs_ack_o  out  1   WB ack, one-cycle pulse, registered
//  wbs_dat_o  out  32  WB read data, valid with ack on reads
//  cmd_val    out  1   FIFO head valid
//  cmd_rdy    in   1   consumer accepts head when cmd_val&cmd_rdy
//  cmd_win    out  2   window index of head command
//  cmd_adr    out  32  head address with window-mask bits cleared (offset)
//  cmd_we     out  1   head is write
//  cmd_sel    out  4   head byte selects
//  cmd_dat    out  32  head write data
//  rd_ack     in   1   read data valid from consumer
//  rd_dat     in   32  read data
//  busy       out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, wbs_ack_o=0, wbs_dat_o=0, cmd_val=0, cmd_win/adr/we/sel/dat=0, busy=0, timer=0.
//  Decode: hit_i = (wbs_adr_i & MASK_i)==BASE_i; lowest index wins on overlap; no hit -> request ignored (no ack).
//  FSM IDLE: req = cyc&stb&hit.
//   write, FIFO not full -> push {win,offset,we,sel,dat}; -> WACK.   write, FIFO full -> stay IDLE (stall).
//   read, FIFO not full -> push; -> RWAIT.                           read, FIFO full -> stall.
//  WACK: wbs_ack_o=1 this cycle (push edge N, ack in N+1); -> IDLE. No accept in WACK (no double push).
//  RWAIT: wait rd_ack (consumer returns reads in order; only one read outstanding by construction).
//   rd_ack -> capture rd_dat; if cyc still high -> RACK, else -> IDLE (data discarded, no ack).
//  RACK: wbs_ack_o=1, wbs_dat_o=captured data; -> IDLE. wbs_dat_o holds last value otherwise.
//  rd_ack outside RWAIT: ignored. cyc dropped in IDLE/WACK: no effect on queued commands.
//  FIFO: push and pop same cycle legal at any occupancy incl. full (count unchanged); pop on empty impossible
//   (cmd_val=0); pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
//  cmd_* driven from FIFO head registers; cmd_val stable until accepted; head data stable while cmd_val&~cmd_rdy.
//  Reset mid-operation: FIFO flushed, in-flight read abandoned, no ack issued; later rd_ack ignored.
// CONFIGURATION
//  WB_SLAVE_Q_TIMEOUT_EN defined: timer cleared on RWAIT entry, increments each RWAIT cycle; at ==TIMEOUT
//   without rd_ack -> RACK with wbs_dat_o=TIMEOUT_DAT; rd_ack in same cycle as expiry wins (real data).
//   Late rd_ack after timeout is ignored.
//  Not defined: no timer logic; RWAIT waits indefinitely.
// STRUCTURE
//  toysram.vh: FSM state encodings (IDLE,WACK,RWAIT,RACK), CMD entry width localparam, clog2 macro.
//  Sub-module wb_cmd_fifo (DEPTH, WIDTH params; push/full, pop/empty/count); wb_slave_q holds decode + FSM.
// TESTING
//  1 write adr 30000010 dat 11223344 sel F, cmd_rdy=1 -> ack N+1; cmd_val adr 00000010 win 0 dat 11223344.
//  2 read adr 30100020, rd_ack 3 cycles after cmd pop with rd_dat CAFEF00D -> ack 1 cycle later, dat CAFEF00D, win 1.
//  3 cmd_rdy=0, 5 writes -> first 4 acked, 5th stalls; pulse cmd_rdy once -> 5th acked, count stays 4.
//  4 adr 40000000 cyc/stb held 20 cycles -> no ack, no push, busy=0.
//  5 TIMEOUT_EN, TIMEOUT=8, read with no rd_ack -> ack at cycle 9 of RWAIT, dat DEADDEAD; late rd_ack ignored.
//  6 rst asserted in RWAIT with 2 queued cmds -> next cycle cmd_val=0, busy=0, no ack; new write works normally.

Source files
------------

// File: rtl/wb_slave_q_pkg.sv
// Shared types for the Wishbone command-queue slave:
// FSM states, queued command entry layout and its width.
package wb_slave_q_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WACK,
    ST_RWAIT,
    ST_RACK
  } state_e;

  typedef struct packed {
    logic [1:0]  win;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH, head presented from storage registers.
// Ports: push_i/din_i/full_o in, pop_i/head_o/empty_o/count_o out.
module wb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q;
  logic [AW-1:0]    wptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  // A pop frees the head slot, so a push is allowed even when full.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_slave_q.sv
// Wishbone slave bridge: window decode, command FIFO, posted writes,
// reads held until rd_ack. Optional read timeout: WB_SLAVE_Q_TIMEOUT_EN.
// Ports: wbs_* Wishbone slave side; cmd_* valid/ready command stream;
// rd_ack/rd_dat read return; busy = queue non-empty or FSM not idle.
module wb_slave_q
  import wb_slave_q_pkg::*;
#(
  parameter int              NWIN        = 2,
  parameter logic [NWIN*32-1:0] WIN_BASE = {32'h30100000, 32'h30000000},
  parameter logic [NWIN*32-1:0] WIN_MASK = {32'hFFF00000, 32'hFFF00000},
  parameter int              DEPTH       = 4,
  parameter int              TIMEOUT     = 255,
  parameter logic [31:0]     TIMEOUT_DAT = 32'hDEADDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_val,
  input  logic        cmd_rdy,
  output logic [1:0]  cmd_win,
  output logic [31:0] cmd_adr,
  output logic        cmd_we,
  output logic [3:0]  cmd_sel,
  output logic [31:0] cmd_dat,
  input  logic        rd_ack,
  input  logic [31:0] rd_dat,
  output logic        busy
);

  state_e      state_q;
  logic        ack_q;
  logic [31:0] dat_q;

  logic        hit;
  logic [1:0]  win;
  logic [31:0] win_mask;
  cmd_t        ent;
  cmd_t        head;
  logic        full;
  logic        empty;
  logic [$clog2(DEPTH):0] count;
  logic        req;
  logic        push;

  // Scan high to low so the lowest matching window wins.
  always_comb begin
    hit      = 1'b0;
    win      = '0;
    win_mask = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if ((wbs_adr_i & WIN_MASK[32*i+:32]) == WIN_BASE[32*i+:32]) begin
        hit      = 1'b1;
        win      = 2'(i);
        win_mask = WIN_MASK[32*i+:32];
      end
    end
  end

  assign ent.win = win;
  assign ent.adr = wbs_adr_i & ~win_mask;
  assign ent.we  = wbs_we_i;
  assign ent.sel = wbs_sel_i;
  assign ent.dat = wbs_dat_i;

  assign req  = wbs_cyc_i & wbs_stb_i & hit;
  assign push = (state_q == ST_IDLE) & req
              & (~full | (cmd_val & cmd_rdy));

  wb_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (ent),
    .full_o  (full),
    .pop_i   (cmd_rdy),
    .empty_o (empty),
    .count_o (count),
    .head_o  (head)
  );

  assign cmd_val = ~empty;
  assign cmd_win = head.win;
  assign cmd_adr = head.adr;
  assign cmd_we  = head.we;
  assign cmd_sel = head.sel;
  assign cmd_dat = head.dat;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign busy      = (count != '0) | (state_q != ST_IDLE);

`ifdef WB_SLAVE_Q_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
`endif

  // Ack is registered: it is raised on the edge entering WACK/RACK
  // so it is high for exactly the cycle spent in those states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
`ifdef WB_SLAVE_Q_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
`ifdef WB_SLAVE_Q_TIMEOUT_EN
          timer_q <= '0;
`endif
          if (push) begin
            if (wbs_we_i) begin
              state_q <= ST_WACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_RWAIT;
            end
          end
        end
        ST_WACK: state_q <= ST_IDLE;
        ST_RWAIT: begin
          if (rd_ack) begin
            // Master gone: drop the data silently.
            if (wbs_cyc_i) begin
              state_q <= ST_RACK;
              ack_q   <= 1'b1;
              dat_q   <= rd_dat;
            end else begin
              state_q <= ST_IDLE;
            end
          end
`ifdef WB_SLAVE_Q_TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT)) begin
            state_q <= ST_RACK;
            ack_q   <= 1'b1;
            dat_q   <= TIMEOUT_DAT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        ST_RACK: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_q.sv
// Self-checking bench for wb_slave_q: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_wb_slave_q;

  localparam int          DEPTH = 4;
  localparam int          TB_TO = 8;
  localparam logic [31:0] TO_DAT = 32'hDEADDEAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        cmd_val;
  logic        cmd_rdy = 1'b0;
  logic [1:0]  cmd_win;
  logic [31:0] cmd_adr;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_dat = '0;
  logic        busy;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_slave_q #(
    .NWIN        (2),
    .WIN_BASE    ({32'h30100000, 32'h30000000}),
    .WIN_MASK    ({32'hFFF00000, 32'hFFF00000}),
    .DEPTH       (DEPTH),
    .TIMEOUT     (TB_TO),
    .TIMEOUT_DAT (TO_DAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (dat_i),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .cmd_val   (cmd_val),
    .cmd_rdy   (cmd_rdy),
    .cmd_win   (cmd_win),
    .cmd_adr   (cmd_adr),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_dat   (cmd_dat),
    .rd_ack    (rd_ack),
    .rd_dat    (rd_dat),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] BASE [2] = '{32'h30000000, 32'h30100000};
  logic [31:0] MASK [2] = '{32'hFFF00000, 32'hFFF00000};

  logic [70:0] q[$];
  bit          m_ack = 0;
  bit          m_rd = 0;
  logic [31:0] m_dat = '0;
  int          m_t = 0;
  bit          started = 0;
  bit          m_hit, m_pop, m_acc, n_ack, n_rd;
  int          m_win;
  logic [31:0] n_dat;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      q.delete();
      m_ack = 0;
      m_rd = 0;
      m_dat = '0;
      m_t = 0;
    end else begin
      m_hit = 0;
      m_win = 0;
      for (int i = 1; i >= 0; i--)
        if ((adr & MASK[i]) == BASE[i]) begin
          m_hit = 1;
          m_win = i;
        end
      m_pop = (q.size() > 0) && cmd_rdy;
      m_acc = !m_ack && !m_rd && cyc && stb && m_hit
              && (q.size() < DEPTH || m_pop);
      n_ack = 0;
      n_rd = m_rd;
      n_dat = m_dat;
      if (m_rd) begin
        if (rd_ack) begin
          n_rd = 0;
          if (cyc) begin
            n_ack = 1;
            n_dat = rd_dat;
          end
        end
`ifdef WB_SLAVE_Q_TIMEOUT_EN
        else if (m_t == TB_TO) begin
          n_rd = 0;
          n_ack = 1;
          n_dat = TO_DAT;
        end else m_t++;
`endif
      end
      if (m_acc) begin
        if (we) n_ack = 1;
        else begin
          n_rd = 1;
          m_t = 0;
        end
      end
      if (m_pop) void'(q.pop_front());
      if (m_acc)
        q.push_back({2'(m_win), adr & ~MASK[m_win], we, sel, dat_i});
      m_ack = n_ack;
      m_rd = n_rd;
      m_dat = n_dat;
    end
  end

  logic [70:0] hd;
  always @(negedge clk) begin
    if (started) begin
      chk("ack", 32'(ack), 32'(m_ack));
      chk("rdata", dat_o, m_dat);
      chk("busy", 32'(busy), 32'(q.size() > 0 || m_ack || m_rd));
      chk("cmd_val", 32'(cmd_val), 32'(q.size() > 0));
      if (q.size() > 0) begin
        hd = q[0];
        chk("cmd_win", 32'(cmd_win), 32'(hd[70:69]));
        chk("cmd_adr", cmd_adr, hd[68:37]);
        chk("cmd_we", 32'(cmd_we), 32'(hd[36]));
        chk("cmd_sel", 32'(cmd_sel), 32'(hd[35:32]));
        chk("cmd_dat", cmd_dat, hd[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input string nm, output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack) begin
        n = i;
        break;
      end
    end
    chk({nm, "_ack_seen"}, 32'(n != 0), 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int n);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = a; dat_i = d; sel = s;
    wait_ack("wr", n);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_rd_start(input logic [31:0] a);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; adr = a; sel = 4'hF;
  endtask

  int n;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_val", 32'(cmd_val), 0);
    chk("rst_adr", cmd_adr, 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 0;

    // 1: posted write, ack one cycle after push
    cmd_rdy = 1;
    wb_write(32'h30000010, 32'h11223344, 4'hF, n);
    chk("t1_lat", n, 1);
    chk("t1_adr", cmd_adr, 32'h00000010);
    chk("t1_win", 32'(cmd_win), 0);
    chk("t1_dat", cmd_dat, 32'h11223344);
    chk("t1_we", 32'(cmd_we), 1);
    repeat (2) @(negedge clk);

    // 2: read in window 1, rd_ack 3 cycles after pop
    wb_rd_start(32'h30100020);
    @(negedge clk);
    chk("t2_val", 32'(cmd_val), 1);
    chk("t2_win", 32'(cmd_win), 1);
    chk("t2_adr", cmd_adr, 32'h00000020);
    repeat (3) @(negedge clk);
    rd_ack = 1; rd_dat = 32'hCAFEF00D;
    @(negedge clk);
    rd_ack = 0;
    chk("t2_ack", 32'(ack), 1);
    chk("t2_dat", dat_o, 32'hCAFEF00D);
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);

    // 2b: master drops cyc before rd_ack, data discarded
    wb_rd_start(32'h30000080);
    @(negedge clk);
    cyc = 0; stb = 0;
    repeat (2) @(negedge clk);
    rd_ack = 1; rd_dat = 32'h12345678;
    @(negedge clk);
    rd_ack = 0;
    repeat (2) @(negedge clk);
    chk("t2b_dat", dat_o, 32'hCAFEF00D);
    chk("t2b_busy", 32'(busy), 0);

    // stray rd_ack while idle
    rd_ack = 1; rd_dat = 32'h55555555;
    @(negedge clk);
    rd_ack = 0;

    // 3: fill queue, 5th write stalls, one pop admits it
    cmd_rdy = 0;
    for (int i = 0; i < 4; i++)
      wb_write(32'h30000100 + 32'(4*i), 32'hA0 + 32'(i), 4'(i + 1), n);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h30100200;
    dat_i = 32'hB5B5B5B5; sel = 4'h3;
    repeat (5) @(negedge clk);
    chk("t3_stall", 32'(ack), 0);
    chk("t3_full", 32'(dut.u_fifo.count_o), 4);
    cmd_rdy = 1;
    @(negedge clk);
    cmd_rdy = 0;
    chk("t3_ack", 32'(ack), 1);
    chk("t3_cnt", 32'(dut.u_fifo.count_o), 4);
    chk("t3_head", cmd_dat, 32'hA1);
    cyc = 0; stb = 0; we = 0;
    cmd_rdy = 1;
    repeat (6) @(negedge clk);
    chk("t3_empty", 32'(cmd_val), 0);

    // 4: unmapped address ignored
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h40000000;
    repeat (20) @(negedge clk);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_val", 32'(cmd_val), 0);
    cyc = 0; stb = 0; we = 0;

`ifdef WB_SLAVE_Q_TIMEOUT_EN
    // 5: read with no rd_ack times out
    wb_rd_start(32'h30000300);
    wait_ack("t5", n);
    chk("t5_dat", dat_o, TO_DAT);
    cyc = 0; stb = 0;
    @(negedge clk);
    rd_ack = 1; rd_dat = 32'h77777777;
    @(negedge clk);
    rd_ack = 0;
    repeat (2) @(negedge clk);
    chk("t5_late", dat_o, TO_DAT);
`endif

    // 6: reset while a read waits with 2 queued commands
    cmd_rdy = 0;
    wb_write(32'h30000040, 32'h0BADF00D, 4'hF, n);
    wb_rd_start(32'h30100044);
    repeat (2) @(negedge clk);
    chk("t6_busy", 32'(busy), 1);
    chk("t6_cnt", 32'(dut.u_fifo.count_o), 2);
    rst = 1;
    cyc = 0; stb = 0;
    @(negedge clk);
    rst = 0;
    chk("t6_val", 32'(cmd_val), 0);
    chk("t6_bz", 32'(busy), 0);
    chk("t6_ack", 32'(ack), 0);
    rd_ack = 1; rd_dat = 32'h99999999;
    @(negedge clk);
    rd_ack = 0;
    cmd_rdy = 1;
    wb_write(32'h30100008, 32'h01020304, 4'h1, n);
    chk("t6_lat", n, 1);
    chk("t6_win", 32'(cmd_win), 1);
    chk("t6_adr", cmd_adr, 32'h00000008);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
